aes_round_engine: RTL and testbench
===================================

Name: aes_round_engine

Overview:
- Iterative single-round AES core; generalises the fixed AES-128 cipher datapath to NR = 10/12/14 rounds (AES-128/192/256) and adds a decrypt mode.
- Owns its round counter and FSM, and uses valid/ready handshakes on the input and output.
- Sits between the input packer and the output serializer.
- Requests one round key per cycle by index from the key-schedule store.

Parameters:
- DATA_WIDTH, 32: state word width. Only 32 is legal.
- NR, 10: number of rounds. Legal values are 10, 12 or 14. Any other value is a compile-time error.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid_in  in  1  block on text_*_in and mode_in is valid
- in_ready_out  out  1  engine can accept a block
- mode_in  in  1  0 = encrypt, 1 = decrypt; sampled on acceptance
- text_0_in..text_3_in  in  DATA_WIDTH each  input state columns 0..3; byte 0 of each column in [31:24]
- key_round_out  out  4  round-key index requested this cycle
- key_0_in..key_3_in  in  DATA_WIDTH each  round key for key_round_out; combinational from the store, same cycle
- text_0_out..text_3_out  out  DATA_WIDTH each  result columns 0..3
- out_valid_out  out  1  result valid
- out_ready_in  in  1  downstream accepts the result
- busy_out  out  1  block in flight (ROUND or DONE)

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state:
  - FSM = IDLE, round counter = 0, mode register = 0.
  - state registers and text_*_out = 0.
  - in_ready_out = 1, out_valid_out = 0, busy_out = 0.
- Reset asserted mid-operation discards the block in flight with no output.
- FSM IDLE:
  - in_ready_out = 1.
  - key_round_out = mode_in ? NR : 0, combinational.
  - If in_valid_in = 1: state <= text ^ key (round 0, ARK only); mode latched; cnt <= 1; go to ROUND.
- FSM ROUND:
  - in_ready_out = 0. One round is applied per clock; the state register updates on each edge.
  - Encrypt, cnt = 1..NR-1: SubBytes -> ShiftRows -> MixColumns -> ARK.
  - Encrypt, cnt = NR: SubBytes -> ShiftRows -> ARK.
  - Decrypt, cnt = 1..NR-1: InvShiftRows -> InvSubBytes -> ARK -> InvMixColumns.
  - Decrypt, cnt = NR: InvShiftRows -> InvSubBytes -> ARK.
  - key_round_out = encrypt ? cnt : NR - cnt.
  - cnt increments each cycle. On the cnt = NR edge: go to DONE, out_valid_out <= 1.
- FSM DONE:
  - out_valid_out = 1. text_*_out (= state register) is held stable until out_ready_in = 1.
  - On out_valid_out & out_ready_in: go to IDLE, out_valid_out <= 0.
  - in_ready_out = 0 in DONE; there is no back-to-back acceptance.
- Latency: acceptance edge to out_valid_out high is exactly NR edges (10/12/14). Throughput is one block per NR+2 cycles when out_ready_in is held at 1.
- Ignored inputs:
  - in_valid_in is ignored in ROUND and DONE.
  - mode_in and text_*_in changes after acceptance have no effect.
  - out_ready_in is ignored unless out_valid_out = 1.
- key_round_out is 0 in DONE. key_*_in is ignored outside the acceptance cycle and ROUND.
- Round counter is 4 bits with no wrap; the maximum value reached is NR <= 14.
- Submodules:
  - Forward: the existing SubBytes, ShiftRows, MixColumns and AddRoundKey modules.
  - Inverse: new InvSubBytes, InvShiftRows and InvMixColumns modules with the same port style.

Test Plan:
- Encrypt, NR=10: pt 00112233445566778899aabbccddeeff, FIPS-197 C.1 key 000102..0f expanded by the bench model -> out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid_out exactly 10 edges after acceptance; key_round_out sequence 0,1..10.
- Decrypt, NR=10: ct 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff; key_round_out sequence 10,9..0.
- NR=14 build, encrypt: key 00..1f, same pt -> 8ea2b7ca516745bfeafc49904b496089 after 14 edges; decrypt round-trips. NR=12 build with key 00..17 -> dda97ca4864cdfe06eaf70a0ec0d7191.
- Backpressure: hold out_ready_in = 0 for 20 cycles in DONE -> outputs stable and in_ready_out = 0; in_valid_in pulses ignored; release -> IDLE next edge.
- Reset: assert rst_n = 0 at round 5 -> all outputs 0 immediately (async); after release, a fresh block gives the correct C.1 result.
- Random mode/text/key (1000 blocks, random out_ready_in stalls) -> matches the reference model; no in_ready_out & busy_out overlap.

Source files
------------

// File: rtl/aes_round_engine.sv
// Iterative AES round engine: one cipher or inverse-cipher round per clock for NR = 10/12/14,
// with valid/ready handshakes and a per-cycle round-key index request.
module aes_round_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int NR         = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic                  mode_in,
    input  logic [DATA_WIDTH-1:0] text_0_in,
    input  logic [DATA_WIDTH-1:0] text_1_in,
    input  logic [DATA_WIDTH-1:0] text_2_in,
    input  logic [DATA_WIDTH-1:0] text_3_in,
    output logic [3:0]            key_round_out,
    input  logic [DATA_WIDTH-1:0] key_0_in,
    input  logic [DATA_WIDTH-1:0] key_1_in,
    input  logic [DATA_WIDTH-1:0] key_2_in,
    input  logic [DATA_WIDTH-1:0] key_3_in,
    output logic [DATA_WIDTH-1:0] text_0_out,
    output logic [DATA_WIDTH-1:0] text_1_out,
    output logic [DATA_WIDTH-1:0] text_2_out,
    output logic [DATA_WIDTH-1:0] text_3_out,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic                  busy_out
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("aes_round_engine: DATA_WIDTH must be 32");
    end
    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
        $error("aes_round_engine: NR must be 10, 12 or 14");
    end

    localparam logic [3:0] NR4 = 4'(NR);

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xtime(x);
            y = y >> 1;
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 by an addition chain; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a6, a12, a14, a15, a30, a60, a120, a240;
        a2   = gmul(a, a);
        a3   = gmul(a2, a);
        a6   = gmul(a3, a3);
        a12  = gmul(a6, a6);
        a14  = gmul(a12, a2);
        a15  = gmul(a12, a3);
        a30  = gmul(a15, a15);
        a60  = gmul(a30, a30);
        a120 = gmul(a60, a60);
        a240 = gmul(a120, a120);
        return gmul(a240, a14);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w, input logic inv);
        logic [7:0] a0, a1, a2, a3, c0, c1, c2, c3;
        {a0, a1, a2, a3} = w;
        c0 = inv ? 8'h0e : 8'h02;
        c1 = inv ? 8'h0b : 8'h03;
        c2 = inv ? 8'h0d : 8'h01;
        c3 = inv ? 8'h09 : 8'h01;
        return {gmul(a0, c0) ^ gmul(a1, c1) ^ gmul(a2, c2) ^ gmul(a3, c3),
                gmul(a0, c3) ^ gmul(a1, c0) ^ gmul(a2, c1) ^ gmul(a3, c2),
                gmul(a0, c2) ^ gmul(a1, c3) ^ gmul(a2, c0) ^ gmul(a3, c1),
                gmul(a0, c1) ^ gmul(a1, c2) ^ gmul(a2, c3) ^ gmul(a3, c0)};
    endfunction

    function automatic logic [127:0] mix_all(input logic [127:0] s, input logic inv);
        return {mix_col(s[127:96], inv), mix_col(s[95:64], inv),
                mix_col(s[63:32], inv), mix_col(s[31:0], inv)};
    endfunction

    // Byte (row r, column c) lives at index 4c+r, MSB first; (Inv)ShiftRows is folded into the S-box gather.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic dec, input logic last);
        logic [127:0] t;
        t = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                t[127-8*(4*c+r) -: 8] = dec ? inv_sbox(s[127-8*(4*((c+4-r)%4)+r) -: 8])
                                            : sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        if (!dec && !last) t = mix_all(t, 1'b0);
        t = t ^ k;
        if (dec && !last) t = mix_all(t, 1'b1);
        return t;
    endfunction

    fsm_t         fsm;
    logic [3:0]   cnt;
    logic         mode;
    logic [127:0] state;
    logic [127:0] round_key;
    logic [127:0] next_state;
    logic         last;

    assign round_key  = {key_0_in, key_1_in, key_2_in, key_3_in};
    assign last       = (cnt == NR4);
    assign next_state = aes_round(state, round_key, mode, last);
    assign {text_0_out, text_1_out, text_2_out, text_3_out} = state;

    always_comb begin
        key_round_out = 4'd0;
        case (fsm)
            IDLE:    key_round_out = mode_in ? NR4 : 4'd0;
            ROUND:   key_round_out = mode ? (NR4 - cnt) : cnt;
            default: key_round_out = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm           <= IDLE;
            cnt           <= 4'd0;
            mode          <= 1'b0;
            state         <= '0;
            in_ready_out  <= 1'b1;
            out_valid_out <= 1'b0;
            busy_out      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid_in) begin
                        state        <= {text_0_in, text_1_in, text_2_in, text_3_in} ^ round_key;
                        mode         <= mode_in;
                        cnt          <= 4'd1;
                        fsm          <= ROUND;
                        in_ready_out <= 1'b0;
                        busy_out     <= 1'b1;
                    end
                end
                ROUND: begin
                    state <= next_state;
                    if (last) begin
                        fsm           <= DONE;
                        out_valid_out <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready_in) begin
                        fsm           <= IDLE;
                        out_valid_out <= 1'b0;
                        busy_out      <= 1'b0;
                        in_ready_out  <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Testbench for aes_round_engine: NR=10/12/14 instances against FIPS-197 vectors and a byte-level AES model.
module tb_aes_round_engine;

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [3];
    logic        mode      [3];
    logic        out_ready [3];
    logic [31:0] text_in   [3][4];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        busy      [3];
    logic [3:0]  kround    [3];
    logic [31:0] key_in    [3][4];
    logic [31:0] text_out  [3][4];

    logic [31:0] rks [3][16][4];
    logic [7:0]  sb  [256];
    logic [7:0]  isb [256];
    logic [3:0]  kseq [20];
    int          kn;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_round_engine #(.DATA_WIDTH(32), .NR(10 + 2 * g)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .in_valid_in   (in_valid[g]),
            .in_ready_out  (in_ready[g]),
            .mode_in       (mode[g]),
            .text_0_in     (text_in[g][0]),
            .text_1_in     (text_in[g][1]),
            .text_2_in     (text_in[g][2]),
            .text_3_in     (text_in[g][3]),
            .key_round_out (kround[g]),
            .key_0_in      (key_in[g][0]),
            .key_1_in      (key_in[g][1]),
            .key_2_in      (key_in[g][2]),
            .key_3_in      (key_in[g][3]),
            .text_0_out    (text_out[g][0]),
            .text_1_out    (text_out[g][1]),
            .text_2_out    (text_out[g][2]),
            .text_3_out    (text_out[g][3]),
            .out_valid_out (out_valid[g]),
            .out_ready_in  (out_ready[g]),
            .busy_out      (busy[g])
        );
        for (genvar j = 0; j < 4; j++) begin : g_key
            assign key_in[g][j] = rks[g][kround[g]][j];
        end
    end

    // ---------------- reference model ----------------
    function automatic int gm(input int a, input int b);
        int p, x, y;
        p = 0; x = a; y = b;
        while (y != 0) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 283;
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic int rl(input int v, input int n);
        return ((v << n) | (v >> (8 - n))) & 255;
    endfunction

    function automatic void build_tables();
        int v, s;
        for (int x = 0; x < 256; x++) begin
            v = 0;
            for (int y = 1; y < 256; y++) if (gm(x, y) == 1) v = y;
            s = v ^ rl(v, 1) ^ rl(v, 2) ^ rl(v, 3) ^ rl(v, 4) ^ 99;
            sb[x] = 8'(s);
            isb[s & 255] = 8'(x);
        end
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
    endfunction

    task automatic load_key(input int g, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        int nk, nr, rcon;
        nr = 10 + 2 * g;
        nk = nr - 6;
        rcon = 1;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {8'(rcon), 24'h0};
                rcon = gm(rcon, 2);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            for (int j = 0; j < 4; j++) rks[g][r][j] = w[4*r+j];
    endtask

    function automatic logic [127:0] m_ark(input int g, input int r, input logic [127:0] x);
        return x ^ {rks[g][r][0], rks[g][r][1], rks[g][r][2], rks[g][r][3]};
    endfunction

    function automatic logic [127:0] m_sub(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        for (int k = 0; k < 16; k++)
            y[127-8*k -: 8] = inv ? isb[x[127-8*k -: 8]] : sb[x[127-8*k -: 8]];
        return y;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        int src;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
                y[127-8*(4*c+r) -: 8] = x[127-8*(4*src+r) -: 8];
            end
        return y;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] x, input bit inv);
        logic [127:0] y;
        int cf [4];
        int acc;
        if (inv) begin cf[0] = 14; cf[1] = 11; cf[2] = 13; cf[3] = 9; end
        else begin cf[0] = 2; cf[1] = 3; cf[2] = 1; cf[3] = 1; end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gm(cf[(k - r + 4) % 4], int'(x[127-8*(4*c+k) -: 8]));
                y[127-8*(4*c+r) -: 8] = 8'(acc);
            end
        return y;
    endfunction

    function automatic logic [127:0] model(input int g, input bit dec, input logic [127:0] blk);
        logic [127:0] x;
        int nr;
        nr = 10 + 2 * g;
        if (!dec) begin
            x = m_ark(g, 0, blk);
            for (int r = 1; r < nr; r++) x = m_ark(g, r, m_mix(m_shift(m_sub(x, 1'b0), 1'b0), 1'b0));
            x = m_ark(g, nr, m_shift(m_sub(x, 1'b0), 1'b0));
        end else begin
            x = m_ark(g, nr, blk);
            for (int r = nr - 1; r >= 1; r--) x = m_mix(m_ark(g, r, m_sub(m_shift(x, 1'b1), 1'b1)), 1'b1);
            x = m_ark(g, 0, m_sub(m_shift(x, 1'b1), 1'b1));
        end
        return x;
    endfunction

    // ---------------- drivers (called at posedge+1 with the instance idle) ----------------
    task automatic start_block(input int g, input bit m, input logic [127:0] blk);
        mode[g] = m;
        {text_in[g][0], text_in[g][1], text_in[g][2], text_in[g][3]} = blk;
        in_valid[g] = 1'b1;
        #1;
        kseq[0] = kround[g];
        kn = 1;
        @(posedge clk); #1;
        in_valid[g] = 1'b0;
        mode[g] = 1'($urandom);
        {text_in[g][0], text_in[g][1], text_in[g][2], text_in[g][3]} = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_result(input int g, input bit poke, output logic [127:0] res, output int lat);
        lat = 0;
        while (out_valid[g] !== 1'b1 && lat < 40) begin
            if (kn < 20) begin kseq[kn] = kround[g]; kn++; end
            if (poke) begin
                in_valid[g]  = 1'($urandom);
                out_ready[g] = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid[g]  = 1'b0;
        out_ready[g] = 1'b0;
        res = {text_out[g][0], text_out[g][1], text_out[g][2], text_out[g][3]};
    endtask

    task automatic release_out(input int g);
        out_ready[g] = 1'b1;
        @(posedge clk); #1;
        out_ready[g] = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (in_ready[g] !== 1'b1 || out_valid[g] !== 1'b0 || busy[g] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl inst=%0d got rdy=%b vld=%b busy=%b need 1/0/0", g, in_ready[g], out_valid[g], busy[g]);
            end
            checks++;
            if ({text_out[g][0], text_out[g][1], text_out[g][2], text_out[g][3]} !== 128'h0) begin
                errors++;
                $display("FAIL reset_text inst=%0d got=%h need 0", g, {text_out[g][0], text_out[g][1], text_out[g][2], text_out[g][3]});
            end
            checks++;
            if (kround[g] !== 4'd0) begin
                errors++;
                $display("FAIL reset_kround inst=%0d got=%0d need 0", g, kround[g]);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_ctrl got rdy=%b vld=%b busy=%b need 1/0/0", in_ready[0], out_valid[0], busy[0]);
        end
    endtask

    task automatic test_known(input int g, input logic [255:0] key, input logic [127:0] ct);
        logic [127:0] res;
        int lat, nr;
        nr = 10 + 2 * g;
        load_key(g, key);
        for (int d = 0; d < 2; d++) begin
            start_block(g, d[0], d == 0 ? PT : ct);
            wait_result(g, 1'b0, res, lat);
            checks++;
            if (lat != nr) begin
                errors++;
                $display("FAIL latency nr=%0d dec=%0d got=%0d need=%0d", nr, d, lat, nr);
            end
            checks++;
            if (res !== (d == 0 ? ct : PT)) begin
                errors++;
                $display("FAIL result nr=%0d dec=%0d got=%h need=%h", nr, d, res, d == 0 ? ct : PT);
            end
            checks++;
            if (kn != nr + 1) begin
                errors++;
                $display("FAIL key_seq_len nr=%0d dec=%0d got=%0d need=%0d", nr, d, kn, nr + 1);
            end
            for (int i = 0; i <= nr; i++) begin
                checks++;
                if (kseq[i] !== 4'(d == 0 ? i : nr - i)) begin
                    errors++;
                    $display("FAIL key_seq nr=%0d dec=%0d step=%0d got=%0d need=%0d", nr, d, i, kseq[i], d == 0 ? i : nr - i);
                end
            end
            checks++;
            if (busy[g] !== 1'b1 || in_ready[g] !== 1'b0 || kround[g] !== 4'd0) begin
                errors++;
                $display("FAIL done_ctrl nr=%0d got busy=%b rdy=%b kr=%0d need 1/0/0", nr, busy[g], in_ready[g], kround[g]);
            end
            release_out(g);
            checks++;
            if (out_valid[g] !== 1'b0 || in_ready[g] !== 1'b1 || busy[g] !== 1'b0) begin
                errors++;
                $display("FAIL release nr=%0d got vld=%b rdy=%b busy=%b need 0/1/0", nr, out_valid[g], in_ready[g], busy[g]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] res;
        int lat;
        load_key(0, K128);
        start_block(0, 1'b0, PT);
        wait_result(0, 1'b0, res, lat);
        for (int i = 0; i < 20; i++) begin
            in_valid[0] = 1'($urandom);
            mode[0] = 1'($urandom);
            text_in[0][0] = $urandom;
            @(posedge clk); #1;
            checks++;
            if ({text_out[0][0], text_out[0][1], text_out[0][2], text_out[0][3]} !== CT128) begin
                errors++;
                $display("FAIL stall_text cycle=%0d got=%h need=%h", i, {text_out[0][0], text_out[0][1], text_out[0][2], text_out[0][3]}, CT128);
            end
            checks++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_ctrl cycle=%0d got vld=%b rdy=%b need 1/0", i, out_valid[0], in_ready[0]);
            end
        end
        in_valid[0] = 1'b0;
        release_out(0);
        checks++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_release got vld=%b rdy=%b busy=%b need 0/1/0", out_valid[0], in_ready[0], busy[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_accept got busy=%b need 0", busy[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] res;
        int lat;
        start_block(0, 1'b0, PT);
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL midreset_ctrl got vld=%b busy=%b rdy=%b need 0/0/1", out_valid[0], busy[0], in_ready[0]);
        end
        checks++;
        if ({text_out[0][0], text_out[0][1], text_out[0][2], text_out[0][3]} !== 128'h0) begin
            errors++;
            $display("FAIL midreset_text got=%h need 0", {text_out[0][0], text_out[0][1], text_out[0][2], text_out[0][3]});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        repeat (15) begin @(posedge clk); #1; end
        checks++;
        if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard got vld=%b busy=%b need 0/0", out_valid[0], busy[0]);
        end
        start_block(0, 1'b0, PT);
        wait_result(0, 1'b0, res, lat);
        checks++;
        if (res !== CT128 || lat != 10) begin
            errors++;
            $display("FAIL midreset_fresh got=%h lat=%0d need=%h lat=10", res, lat, CT128);
        end
        release_out(0);
    endtask

    task automatic test_back_to_back();
        int t [$];
        mode[0] = 1'b0;
        {text_in[0][0], text_in[0][1], text_in[0][2], text_in[0][3]} = PT;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #1;
            if (out_valid[0] === 1'b1) begin
                t.push_back(i);
                checks++;
                if ({text_out[0][0], text_out[0][1], text_out[0][2], text_out[0][3]} !== CT128) begin
                    errors++;
                    $display("FAIL b2b_text cycle=%0d got=%h need=%h", i, {text_out[0][0], text_out[0][1], text_out[0][2], text_out[0][3]}, CT128);
                end
            end
        end
        in_valid[0] = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        out_ready[0] = 1'b0;
        checks++;
        if (t.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got=%0d need=3", t.size());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (t[i] - t[i-1] != 12) begin
                    errors++;
                    $display("FAIL b2b_period got=%0d need=12", t[i] - t[i-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] blk, res, expv;
        logic [255:0] key;
        int g, lat;
        bit m;
        for (int n = 0; n < 1000; n++) begin
            g = $urandom_range(0, 2);
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            blk = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom);
            load_key(g, key);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            start_block(g, m, blk);
            wait_result(g, 1'b1, res, lat);
            expv = model(g, m, blk);
            checks++;
            if (res !== expv) begin
                errors++;
                $display("FAIL rand_result blk=%0d nr=%0d dec=%0d got=%h need=%h", n, 10 + 2 * g, m, res, expv);
            end
            checks++;
            if (lat != 10 + 2 * g) begin
                errors++;
                $display("FAIL rand_latency blk=%0d got=%0d need=%0d", n, lat, 10 + 2 * g);
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                checks++;
                if (out_valid[g] !== 1'b1 || {text_out[g][0], text_out[g][1], text_out[g][2], text_out[g][3]} !== expv) begin
                    errors++;
                    $display("FAIL rand_hold blk=%0d got vld=%b text=%h need 1 %h", n, out_valid[g],
                             {text_out[g][0], text_out[g][1], text_out[g][2], text_out[g][3]}, expv);
                end
            end
            release_out(g);
        end
    endtask

    // in_ready and busy must never be high together
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int g = 0; g < 3; g++) begin
                checks++;
                if ((in_ready[g] & busy[g]) === 1'b1) begin
                    errors++;
                    $display("FAIL ready_busy_overlap inst=%0d got rdy=%b busy=%b need not both 1", g, in_ready[g], busy[g]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        for (int g = 0; g < 3; g++) begin
            in_valid[g] = 1'b0;
            mode[g] = 1'b0;
            out_ready[g] = 1'b0;
            for (int j = 0; j < 4; j++) text_in[g][j] = 32'h0;
        end
        build_tables();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_known(0, K128, CT128);
        test_known(1, K192, CT192);
        test_known(2, K256, CT256);
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
